// File: rtl/lsu_bus_initiator.sv
// rtl/lsu_bus_initiator.sv - load/store unit bus initiator (single outstanding transaction)
//
// Purpose: accepts one core load/store request at a time, issues a single-cycle
// bus strobe with lane-aligned write enables and replicated store data, waits
// for ack_i/err_i, and returns a one-cycle response with extended load data.
//
// Optional feature: define LSU_TIMEOUT_EN to abort a WAIT lasting TIMEOUT_CYCLES
// cycles with an error response. Without it WAIT lasts until ack_i/err_i.
//
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   req_valid_i / req_ready_o  core request handshake (ready only in IDLE)
//   req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i  request fields
//   rsp_valid_o                one-cycle response pulse
//   rsp_rdata_o, rsp_err_o, rsp_misaligned_o  response fields (0 when not valid)
//   stb_o, we_o, addr_o, wdata_o  bus request (strobe for one cycle)
//   rdata_i, ack_i, err_i      bus responder
module lsu_bus_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        rsp_misaligned_o,
  output logic        stb_o,
  output logic [3:0]  we_o,
  output logic [31:0] addr_o,
  output logic [31:0] wdata_o,
  input  logic [31:0] rdata_i,
  input  logic        ack_i,
  input  logic        err_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        store_q, store_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        rsp_mis_q, rsp_mis_d;

`ifdef LSU_TIMEOUT_EN
  logic [31:0] tmo_q, tmo_d;
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  // Request decode from the live request fields (used only on acceptance).
  logic        req_mis;
  logic [3:0]  req_we_lanes;
  logic [31:0] req_wdata_rep;

  always_comb begin
    req_mis       = 1'b0;
    req_we_lanes  = 4'b0000;
    req_wdata_rep = req_wdata_i;
    unique case (req_size_i)
      2'b00: begin
        req_we_lanes  = 4'b0001 << req_addr_i[1:0];
        req_wdata_rep = {4{req_wdata_i[7:0]}};
      end
      2'b01: begin
        req_mis       = req_addr_i[0];
        req_we_lanes  = 4'b0011 << req_addr_i[1:0];
        req_wdata_rep = {2{req_wdata_i[15:0]}};
      end
      2'b10: begin
        req_mis       = (req_addr_i[1:0] != 2'b00);
        req_we_lanes  = 4'b1111;
      end
      default: begin
        req_mis       = 1'b1;
      end
    endcase
    if (!req_we_i) begin
      req_we_lanes = 4'b0000;
    end
  end

  // Load lane selection and sign/zero extension of the captured bus word.
  logic [7:0]  sel_b;
  logic [15:0] sel_h;
  logic [31:0] load_ext;

  always_comb begin
    sel_b    = rdata_i[{lane_q, 3'b000} +: 8];
    sel_h    = lane_q[1] ? rdata_i[31:16] : rdata_i[15:0];
    load_ext = rdata_i;
    unique case (size_q)
      2'b00:   load_ext = uns_q ? {24'b0, sel_b} : {{24{sel_b[7]}}, sel_b};
      2'b01:   load_ext = uns_q ? {16'b0, sel_h} : {{16{sel_h[15]}}, sel_h};
      default: load_ext = rdata_i;
    endcase
  end

  // Next-state logic. Response registers default to 0 so they are non-zero
  // only during the RESP cycle that follows their capture.
  always_comb begin
    state_d     = state_q;
    store_d     = store_q;
    size_d      = size_q;
    uns_d       = uns_q;
    lane_d      = lane_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    rsp_mis_d   = 1'b0;
`ifdef LSU_TIMEOUT_EN
    tmo_d       = '0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          store_d = req_we_i;
          size_d  = req_size_i;
          uns_d   = req_unsigned_i;
          lane_d  = req_addr_i[1:0];
          addr_d  = {req_addr_i[31:2], 2'b00};
          we_d    = req_we_lanes;
          wdata_d = req_wdata_rep;
          if (req_mis) begin
            state_d   = S_RESP;
            rsp_mis_d = 1'b1;
          end else begin
            state_d   = S_REQ;
          end
        end
      end
      S_REQ: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (err_i) begin
          state_d   = S_RESP;
          rsp_err_d = 1'b1;
        end else if (ack_i) begin
          state_d     = S_RESP;
          rsp_rdata_d = store_q ? 32'd0 : load_ext;
        end else begin
`ifdef LSU_TIMEOUT_EN
          if (tmo_q >= TIMEOUT_CYCLES - 1) begin
            state_d   = S_RESP;
            rsp_err_d = 1'b1;
          end else begin
            tmo_d = tmo_q + 32'd1;
          end
`endif
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      store_q     <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      lane_q      <= 2'b00;
      addr_q      <= '0;
      we_q        <= '0;
      wdata_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_mis_q   <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      store_q     <= store_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      lane_q      <= lane_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_mis_q   <= rsp_mis_d;
`ifdef LSU_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  // Bus fields are driven only while a transaction is on the bus; otherwise 0.
  logic bus_active;
  assign bus_active       = (state_q == S_REQ) || (state_q == S_WAIT);

  assign req_ready_o      = (state_q == S_IDLE);
  assign stb_o            = (state_q == S_REQ);
  assign addr_o           = bus_active ? addr_q  : 32'd0;
  assign we_o             = bus_active ? we_q    : 4'd0;
  assign wdata_o          = bus_active ? wdata_q : 32'd0;

  assign rsp_valid_o      = (state_q == S_RESP);
  assign rsp_rdata_o      = rsp_rdata_q;
  assign rsp_err_o        = rsp_err_q;
  assign rsp_misaligned_o = rsp_mis_q;

endmodule

// File: tb/tb_lsu_bus_initiator.sv
// tb/tb_lsu_bus_initiator.sv - directed self-checking bench for lsu_bus_initiator
module tb_lsu_bus_initiator;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [1:0]  req_size_i = 2'b00;
  logic        req_unsigned_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        rsp_misaligned_o;
  logic        stb_o;
  logic [3:0]  we_o;
  logic [31:0] addr_o;
  logic [31:0] wdata_o;
  logic [31:0] rdata_i = '0;
  logic        ack_i = 1'b0;
  logic        err_i = 1'b0;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk_i = ~clk_i;

  lsu_bus_initiator #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_we_i(req_we_i), .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .rsp_misaligned_o(rsp_misaligned_o),
    .stb_o(stb_o), .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o),
    .rdata_i(rdata_i), .ack_i(ack_i), .err_i(err_i)
  );

  // Drives one request from a negedge and observes 12 cycles. mode: 0 ack,
  // 1 err, 2 responder silent. Responder answers the cycle after stb_o.
  // Cycle 0 is the acceptance cycle; rsp_cyc is -1 if no response seen.
  task automatic run_txn(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rd, input int mode,
                         output int stb_n, output int rsp_cyc, output logic leak,
                         output logic [31:0] o_addr, output logic [3:0] o_we,
                         output logic [31:0] o_wdata, output logic [31:0] o_rdata,
                         output logic o_err, output logic o_mis);
    int ack_at;
    ack_at = -1; stb_n = 0; rsp_cyc = -1; leak = 1'b0;
    o_addr = '0; o_we = '0; o_wdata = '0; o_rdata = '0; o_err = 1'b0; o_mis = 1'b0;
    req_valid_i = 1'b1; req_we_i = we; req_size_i = size; req_unsigned_i = uns;
    req_addr_i = addr; req_wdata_i = wd;
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      ack_i = 1'b0; err_i = 1'b0;
      if (stb_o) begin
        stb_n++; o_addr = addr_o; o_we = we_o; o_wdata = wdata_o; ack_at = c + 1;
      end
      if (c == ack_at && mode != 2) begin
        if (mode == 1) err_i = 1'b1; else ack_i = 1'b1;
        rdata_i = rd;
      end
      if (rsp_valid_o && rsp_cyc < 0) begin
        rsp_cyc = c; o_rdata = rsp_rdata_o; o_err = rsp_err_o; o_mis = rsp_misaligned_o;
      end
      if (!rsp_valid_o && (rsp_rdata_o != 0 || rsp_err_o || rsp_misaligned_o)) leak = 1'b1;
      @(negedge clk_i);
    end
    ack_i = 1'b0; err_i = 1'b0;
  endtask

  int          t_stb, t_rsp;
  logic        t_leak, t_err, t_mis;
  logic [31:0] t_addr, t_wdata, t_rdata;
  logic [3:0]  t_we;

  task automatic test_reset();
    rst_i = 1'b1;
    @(posedge clk_i); @(posedge clk_i); @(negedge clk_i);
    n_total++; if (req_ready_o !== 1'b1) $display("FAIL reset_ready got %b exp 1", req_ready_o); else n_pass++;
    n_total++;
    if ({stb_o, we_o, addr_o, wdata_o} !== 69'd0)
      $display("FAIL reset_bus got stb=%b we=%b addr=%h wdata=%h exp all 0", stb_o, we_o, addr_o, wdata_o);
    else n_pass++;
    n_total++;
    if ({rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_misaligned_o} !== 35'd0)
      $display("FAIL reset_rsp got v=%b d=%h e=%b m=%b exp all 0", rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_misaligned_o);
    else n_pass++;
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_store();
    run_txn(1'b1, 2'b00, 1'b0, 32'h103, 32'h0000_00AB, 32'h5555_5555, 0,
            t_stb, t_rsp, t_leak, t_addr, t_we, t_wdata, t_rdata, t_err, t_mis);
    n_total++; if (t_stb !== 1) $display("FAIL sb_stb_cycles got %0d exp 1", t_stb); else n_pass++;
    n_total++; if (t_addr !== 32'h100) $display("FAIL sb_addr got %h exp 00000100", t_addr); else n_pass++;
    n_total++; if (t_we !== 4'b1000) $display("FAIL sb_we got %b exp 1000", t_we); else n_pass++;
    n_total++; if (t_wdata !== 32'hABABABAB) $display("FAIL sb_wdata got %h exp abababab", t_wdata); else n_pass++;
    n_total++; if (t_rsp !== 3) $display("FAIL sb_rsp_cycle got %0d exp 3", t_rsp); else n_pass++;
    n_total++;
    if ({t_err, t_mis, t_rdata} !== 34'd0) $display("FAIL sb_rsp_fields got e=%b m=%b d=%h exp 0", t_err, t_mis, t_rdata);
    else n_pass++;
    n_total++; if (t_leak !== 1'b0) $display("FAIL sb_rsp_leak got %b exp 0", t_leak); else n_pass++;
    run_txn(1'b1, 2'b01, 1'b0, 32'h402, 32'h1234_5678, 32'h0, 0,
            t_stb, t_rsp, t_leak, t_addr, t_we, t_wdata, t_rdata, t_err, t_mis);
    n_total++;
    if ({t_we, t_wdata} !== {4'b1100, 32'h5678_5678})
      $display("FAIL sh_lanes got we=%b wdata=%h exp we=1100 wdata=56785678", t_we, t_wdata);
    else n_pass++;
  endtask

  task automatic test_load();
    run_txn(1'b0, 2'b01, 1'b0, 32'h202, 32'h0, 32'h8001_1234, 0,
            t_stb, t_rsp, t_leak, t_addr, t_we, t_wdata, t_rdata, t_err, t_mis);
    n_total++; if (t_rdata !== 32'hFFFF8001) $display("FAIL lh_signed got %h exp ffff8001", t_rdata); else n_pass++;
    n_total++; if (t_we !== 4'b0000) $display("FAIL lh_we got %b exp 0000", t_we); else n_pass++;
    n_total++; if (t_addr !== 32'h200) $display("FAIL lh_addr got %h exp 00000200", t_addr); else n_pass++;
    run_txn(1'b0, 2'b01, 1'b1, 32'h202, 32'h0, 32'h8001_1234, 0,
            t_stb, t_rsp, t_leak, t_addr, t_we, t_wdata, t_rdata, t_err, t_mis);
    n_total++; if (t_rdata !== 32'h0000_8001) $display("FAIL lhu_unsigned got %h exp 00008001", t_rdata); else n_pass++;
    run_txn(1'b0, 2'b00, 1'b0, 32'h1, 32'h0, 32'h1234_8056, 0,
            t_stb, t_rsp, t_leak, t_addr, t_we, t_wdata, t_rdata, t_err, t_mis);
    n_total++; if (t_rdata !== 32'hFFFF_FF80) $display("FAIL lb_lane1 got %h exp ffffff80", t_rdata); else n_pass++;
    run_txn(1'b0, 2'b00, 1'b1, 32'h3, 32'h0, 32'hC634_8056, 0,
            t_stb, t_rsp, t_leak, t_addr, t_we, t_wdata, t_rdata, t_err, t_mis);
    n_total++; if (t_rdata !== 32'h0000_00C6) $display("FAIL lbu_lane3 got %h exp 000000c6", t_rdata); else n_pass++;
  endtask

  task automatic test_bus_error();
    run_txn(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hDEAD_BEEF, 1,
            t_stb, t_rsp, t_leak, t_addr, t_we, t_wdata, t_rdata, t_err, t_mis);
    n_total++;
    if ({t_rsp == 3, t_err, t_rdata} !== {1'b1, 1'b1, 32'd0})
      $display("FAIL err_rsp got cyc=%0d e=%b d=%h exp cyc=3 e=1 d=0", t_rsp, t_err, t_rdata);
    else n_pass++;
  endtask

  task automatic test_misaligned();
    run_txn(1'b0, 2'b10, 1'b0, 32'h6, 32'h0, 32'h1111_1111, 0,
            t_stb, t_rsp, t_leak, t_addr, t_we, t_wdata, t_rdata, t_err, t_mis);
    n_total++; if (t_stb !== 0) $display("FAIL mis_word_stb got %0d exp 0", t_stb); else n_pass++;
    n_total++; if (t_rsp !== 1) $display("FAIL mis_word_cycle got %0d exp 1", t_rsp); else n_pass++;
    n_total++;
    if ({t_mis, t_err, t_rdata} !== {1'b1, 1'b0, 32'd0})
      $display("FAIL mis_word_fields got m=%b e=%b d=%h exp m=1 e=0 d=0", t_mis, t_err, t_rdata);
    else n_pass++;
    run_txn(1'b1, 2'b11, 1'b0, 32'h0, 32'h0, 32'h0, 0,
            t_stb, t_rsp, t_leak, t_addr, t_we, t_wdata, t_rdata, t_err, t_mis);
    n_total++;
    if ({t_stb == 0, t_rsp == 1, t_mis} !== 3'b111)
      $display("FAIL mis_size11 got stb=%0d cyc=%0d m=%b exp stb=0 cyc=1 m=1", t_stb, t_rsp, t_mis);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int acc, rsp_n, stb_n, first_acc, second_acc;
    acc = 0; rsp_n = 0; stb_n = 0; first_acc = -1; second_acc = -1;
    req_valid_i = 1'b1; req_we_i = 1'b1; req_size_i = 2'b10; req_addr_i = 32'h40;
    req_wdata_i = 32'hCAFE_F00D; ack_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (req_ready_o) begin
        acc++;
        if (first_acc < 0) first_acc = c; else if (second_acc < 0) second_acc = c;
      end
      if (rsp_valid_o) rsp_n++;
      if (stb_o) stb_n++;
      @(negedge clk_i);
    end
    req_valid_i = 1'b0; ack_i = 1'b0;
    @(negedge clk_i);
    n_total++;
    if ({acc, rsp_n, stb_n} !== {32'd2, 32'd2, 32'd2})
      $display("FAIL b2b_counts got acc=%0d rsp=%0d stb=%0d exp 2 2 2", acc, rsp_n, stb_n);
    else n_pass++;
    n_total++;
    if (second_acc - first_acc !== 4)
      $display("FAIL b2b_spacing got %0d exp 4", second_acc - first_acc);
    else n_pass++;
  endtask

  task automatic test_reset_in_wait();
    int late_rsp, late_stb;
    late_rsp = 0; late_stb = 0;
    req_valid_i = 1'b1; req_we_i = 1'b0; req_size_i = 2'b10; req_addr_i = 32'h80;
    @(posedge clk_i); @(negedge clk_i);
    req_valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i); @(negedge clk_i);
    rst_i = 1'b0;
    n_total++;
    if ({req_ready_o, rsp_valid_o, stb_o} !== 3'b100)
      $display("FAIL rstwait_idle got ready=%b rspv=%b stb=%b exp 1 0 0", req_ready_o, rsp_valid_o, stb_o);
    else n_pass++;
    ack_i = 1'b1; rdata_i = 32'h1234_5678;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      if (rsp_valid_o) late_rsp++;
      if (stb_o) late_stb++;
    end
    ack_i = 1'b0;
    n_total++;
    if ({late_rsp, late_stb} !== 64'd0)
      $display("FAIL rstwait_late_ack got rsp=%0d stb=%0d exp 0 0", late_rsp, late_stb);
    else n_pass++;
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    int late_rsp;
    late_rsp = 0;
    run_txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h0, 2,
            t_stb, t_rsp, t_leak, t_addr, t_we, t_wdata, t_rdata, t_err, t_mis);
    n_total++; if (t_rsp !== 6) $display("FAIL tmo_cycle got %0d exp 6", t_rsp); else n_pass++;
    n_total++;
    if ({t_err, t_mis, t_rdata} !== {1'b1, 1'b0, 32'd0})
      $display("FAIL tmo_fields got e=%b m=%b d=%h exp e=1 m=0 d=0", t_err, t_mis, t_rdata);
    else n_pass++;
    ack_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      if (rsp_valid_o) late_rsp++;
    end
    ack_i = 1'b0;
    n_total++; if (late_rsp !== 0) $display("FAIL tmo_late_ack got %0d exp 0", late_rsp); else n_pass++;
  endtask
`else
  task automatic test_no_timeout();
    run_txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h0, 2,
            t_stb, t_rsp, t_leak, t_addr, t_we, t_wdata, t_rdata, t_err, t_mis);
    n_total++; if (t_rsp !== -1) $display("FAIL notmo_wait got %0d exp -1", t_rsp); else n_pass++;
    ack_i = 1'b1; rdata_i = 32'h0000_00F0;
    @(negedge clk_i);
    ack_i = 1'b0;
    n_total++;
    if ({rsp_valid_o, rsp_err_o, rsp_rdata_o} !== {1'b1, 1'b0, 32'h0000_00F0})
      $display("FAIL notmo_late_ack got v=%b e=%b d=%h exp v=1 e=0 d=000000f0", rsp_valid_o, rsp_err_o, rsp_rdata_o);
    else n_pass++;
    @(negedge clk_i);
  endtask
`endif

  initial begin
    @(negedge clk_i);
    test_reset();
    test_store();
    test_load();
    test_bus_error();
    test_misaligned();
    test_back_to_back();
    test_reset_in_wait();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
